// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Write-back arbiter for the 16-bit x 8 register file. The ALU and the load
//   unit each push {rd, data} into their own small FIFO via valid/ready.
//   The two FIFO heads are arbitrated round-robin onto the single registered
//   RF write port. A per-register busy bitmap is exported for decode stalls.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data  ALU result handshake in, alu_ready out
//   ld_valid/ld_rd/ld_data     load result handshake in, ld_ready out
//   wr_en/wr_sel/wr_port       registered RF write port
//   write_rf_bool              forwarding capture strobe (same as wr_en)
//   busy                       bit r set while a write to r is pending
module rf_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [ADDR_WIDTH-1:0]    alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    output logic                     alu_ready,
    input  logic                     ld_valid,
    input  logic [ADDR_WIDTH-1:0]    ld_rd,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    output logic                     ld_ready,
    output logic                     wr_en,
    output logic [ADDR_WIDTH-1:0]    wr_sel,
    output logic [DATA_WIDTH-1:0]    wr_port,
    output logic                     write_rf_bool,
    output logic [2**ADDR_WIDTH-1:0] busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int NREG  = 2**ADDR_WIDTH;

    // Source index: 0 = ALU, 1 = load unit.
    localparam logic [0:0] SRC_ALU = 1'b0;
    localparam logic [0:0] SRC_LD  = 1'b1;

    logic [PTR_W-1:0]      wp_q [2];
    logic [PTR_W-1:0]      wp_d [2];
    logic [PTR_W-1:0]      rp_q [2];
    logic [PTR_W-1:0]      rp_d [2];
    logic [ADDR_WIDTH-1:0] rd_mem_q   [2][DEPTH];
    logic [ADDR_WIDTH-1:0] rd_mem_d   [2][DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [2][DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_d [2][DEPTH];

    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_sel_q, wr_sel_d;
    logic [DATA_WIDTH-1:0] wr_port_q, wr_port_d;
    logic [0:0]            last_grant_q, last_grant_d;

    logic [ADDR_WIDTH-1:0] in_rd   [2];
    logic [DATA_WIDTH-1:0] in_data [2];
    logic [ADDR_WIDTH-1:0] head_rd   [2];
    logic [DATA_WIDTH-1:0] head_data [2];
    logic [PTR_W-1:0]      cnt   [2];
    logic [NREG-1:0]       busy_fifo [2];
    logic [1:0]            full, empty, push, pop;

    assign in_rd[0]   = alu_rd;
    assign in_rd[1]   = ld_rd;
    assign in_data[0] = alu_data;
    assign in_data[1] = ld_data;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            cnt[s]       = wp_q[s] - rp_q[s];
            empty[s]     = (wp_q[s] == rp_q[s]);
            full[s]      = (wp_q[s][PTR_W-1] != rp_q[s][PTR_W-1]) &&
                           (wp_q[s][IDX_W-1:0] == rp_q[s][IDX_W-1:0]);
            head_rd[s]   = rd_mem_q[s][rp_q[s][IDX_W-1:0]];
            head_data[s] = data_mem_q[s][rp_q[s][IDX_W-1:0]];
            // Mark the destination of every occupied slot, walking from the head.
            busy_fifo[s] = '0;
            for (int k = 0; k < DEPTH; k++) begin
                if (PTR_W'(k) < cnt[s]) begin
                    busy_fifo[s][rd_mem_q[s][IDX_W'(rp_q[s] + PTR_W'(k))]] = 1'b1;
                end
            end
        end
    end

    // Cross-producer WAW ordering: a result may not enter its FIFO while the
    // other FIFO still holds a write to the same register. On a same-cycle
    // collision the load wins.
    assign ld_ready  = !reset && !full[1] && !busy_fifo[0][ld_rd];
    assign alu_ready = !reset && !full[0] && !busy_fifo[1][alu_rd] &&
                       !(ld_valid && ld_ready && (ld_rd == alu_rd));

    assign push[0] = alu_valid && alu_ready;
    assign push[1] = ld_valid && ld_ready;

    // Round robin: with both heads present, the source not granted last wins.
    assign pop[1] = !empty[1] && (empty[0] || (last_grant_q == SRC_ALU));
    assign pop[0] = !empty[0] && (empty[1] || (last_grant_q == SRC_LD));

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            wp_d[s]       = wp_q[s] + PTR_W'(push[s]);
            rp_d[s]       = rp_q[s] + PTR_W'(pop[s]);
            rd_mem_d[s]   = rd_mem_q[s];
            data_mem_d[s] = data_mem_q[s];
            if (push[s]) begin
                rd_mem_d[s][wp_q[s][IDX_W-1:0]]   = in_rd[s];
                data_mem_d[s][wp_q[s][IDX_W-1:0]] = in_data[s];
            end
        end

        wr_en_d      = pop[0] || pop[1];
        wr_sel_d     = wr_sel_q;
        wr_port_d    = wr_port_q;
        last_grant_d = last_grant_q;
        if (pop[1]) begin
            wr_sel_d     = head_rd[1];
            wr_port_d    = head_data[1];
            last_grant_d = SRC_LD;
        end else if (pop[0]) begin
            wr_sel_d     = head_rd[0];
            wr_port_d    = head_data[0];
            last_grant_d = SRC_ALU;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                wp_q[s] <= '0;
                rp_q[s] <= '0;
            end
            wr_en_q      <= 1'b0;
            wr_sel_q     <= '0;
            wr_port_q    <= '0;
            last_grant_q <= SRC_ALU;
        end else begin
            for (int s = 0; s < 2; s++) begin
                wp_q[s] <= wp_d[s];
                rp_q[s] <= rp_d[s];
            end
            wr_en_q      <= wr_en_d;
            wr_sel_q     <= wr_sel_d;
            wr_port_q    <= wr_port_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

    assign wr_en         = wr_en_q;
    assign write_rf_bool = wr_en_q;
    assign wr_sel        = wr_sel_q;
    assign wr_port       = wr_port_q;
    assign busy          = busy_fifo[0] | busy_fifo[1] |
                           (wr_en_q ? (NREG'(1) << wr_sel_q) : '0);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, ld_valid;
    logic [2:0]  alu_rd, ld_rd;
    logic [15:0] alu_data, ld_data;
    logic        alu_ready, ld_ready;
    logic        wr_en, write_rf_bool;
    logic [2:0]  wr_sel;
    logic [15:0] wr_port;
    logic [7:0]  busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;

    rf_wb_arbiter #(.DEPTH(2), .DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_port(wr_port),
        .write_rf_bool(write_rf_bool), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_en) n_writes++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [2:0] ar, input logic [15:0] ad,
                         input logic lv, input logic [2:0] lr, input logic [15:0] ld);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid  = lv; ld_rd  = lr; ld_data  = ld;
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [2:0] sel, input logic [15:0] port);
        chk({tag, "_en"}, {31'd0, wr_en}, 32'd1);
        chk({tag, "_fwd"}, {31'd0, write_rf_bool}, 32'd1);
        chk({tag, "_sel"}, {29'd0, wr_sel}, {29'd0, sel});
        chk({tag, "_port"}, {16'd0, wr_port}, {16'd0, port});
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0;  ld_rd = 0;  ld_data = 0;

        // 1. reset
        cyc();
        cyc();
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_wr_en", {31'd0, wr_en}, 32'd0);
        chk("idle_wr_sel", {29'd0, wr_sel}, 32'd0);
        chk("idle_wr_port", {16'd0, wr_port}, 32'd0);
        chk("idle_busy", {24'd0, busy}, 32'h00);
        chk("idle_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("idle_ld_ready", {31'd0, ld_ready}, 32'd1);

        // 2. single write latency
        drive(1, 3'd3, 16'hBEEF, 0, 3'd0, 16'h0);
        chk("t2_alu_ready", {31'd0, alu_ready}, 32'd1);
        cyc();
        drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        chk("t2_busy_e0", {24'd0, busy}, 32'h08);
        chk("t2_wr_en_e0", {31'd0, wr_en}, 32'd0);
        cyc();
        chk_wr("t2_wr", 3'd3, 16'hBEEF);
        chk("t2_busy_e1", {24'd0, busy}, 32'h08);
        cyc();
        chk("t2_busy_e2", {24'd0, busy}, 32'h00);
        chk("t2_wr_en_e2", {31'd0, wr_en}, 32'd0);
        chk("t2_sel_hold", {29'd0, wr_sel}, 32'd3);

        // 3. round robin
        drive(1, 3'd4, 16'h0044, 1, 3'd1, 16'h0011);
        cyc();
        drive(1, 3'd5, 16'h0055, 1, 3'd2, 16'h0022);
        chk("t3_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("t3_ld_ready", {31'd0, ld_ready}, 32'd1);
        cyc();
        drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        chk_wr("t3_w0", 3'd1, 16'h0011);
        cyc();
        chk_wr("t3_w1", 3'd4, 16'h0044);
        cyc();
        chk_wr("t3_w2", 3'd2, 16'h0022);
        cyc();
        chk_wr("t3_w3", 3'd5, 16'h0055);
        chk("t3_busy_last", {24'd0, busy}, 32'h20);
        cyc();
        chk("t3_wr_en_end", {31'd0, wr_en}, 32'd0);
        chk("t3_busy_end", {24'd0, busy}, 32'h00);

        // 4. same-rd collision
        drive(1, 3'd6, 16'h2222, 1, 3'd6, 16'h1111);
        chk("t4_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("t4_alu_ready", {31'd0, alu_ready}, 32'd0);
        cyc();
        drive(1, 3'd6, 16'h2222, 0, 3'd0, 16'h0);
        chk("t4_alu_blocked", {31'd0, alu_ready}, 32'd0);
        chk("t4_busy_q", {24'd0, busy}, 32'h40);
        cyc();
        chk_wr("t4_w0", 3'd6, 16'h1111);
        chk("t4_alu_free", {31'd0, alu_ready}, 32'd1);
        cyc();
        drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        chk("t4_wr_gap", {31'd0, wr_en}, 32'd0);
        chk("t4_busy_alu", {24'd0, busy}, 32'h40);
        cyc();
        chk_wr("t4_w1", 3'd6, 16'h2222);
        cyc();
        chk("t4_busy_end", {24'd0, busy}, 32'h00);

        // 5. full FIFO back-pressure
        drive(1, 3'd3, 16'hB003, 1, 3'd0, 16'hA000);
        cyc();
        drive(1, 3'd4, 16'hB004, 1, 3'd1, 16'hA001);
        chk("t5_alu_ready1", {31'd0, alu_ready}, 32'd1);
        cyc();
        drive(1, 3'd5, 16'hB005, 1, 3'd2, 16'hA002);
        chk("t5_alu_full", {31'd0, alu_ready}, 32'd0);
        chk("t5_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk_wr("t5_w0", 3'd0, 16'hA000);
        cyc();
        drive(1, 3'd5, 16'hB005, 0, 3'd0, 16'h0);
        chk("t5_alu_retry", {31'd0, alu_ready}, 32'd1);
        chk_wr("t5_w1", 3'd3, 16'hB003);
        chk("t5_busy", {24'd0, busy}, 32'h1E);
        cyc();
        drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        chk_wr("t5_w2", 3'd1, 16'hA001);
        cyc();
        chk_wr("t5_w3", 3'd4, 16'hB004);
        cyc();
        chk_wr("t5_w4", 3'd2, 16'hA002);
        cyc();
        chk_wr("t5_w5", 3'd5, 16'hB005);
        cyc();
        chk("t5_wr_en_end", {31'd0, wr_en}, 32'd0);
        chk("t5_busy_end", {24'd0, busy}, 32'h00);

        // 6. reset mid-operation
        drive(1, 3'd2, 16'hC002, 1, 3'd1, 16'hC001);
        cyc();
        drive(0, 3'd0, 16'h0, 1, 3'd3, 16'hC003);
        chk("t6_ld_ready", {31'd0, ld_ready}, 32'd1);
        cyc();
        drive(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        chk_wr("t6_w0", 3'd1, 16'hC001);
        chk("t6_busy_pre", {24'd0, busy}, 32'h0E);
        reset = 1'b1;
        cyc();
        chk("t6_wr_en_rst", {31'd0, wr_en}, 32'd0);
        chk("t6_busy_rst", {24'd0, busy}, 32'h00);
        chk("t6_alu_ready_rst", {31'd0, alu_ready}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("t6_wr_en_after", {31'd0, wr_en}, 32'd0);
        chk("t6_busy_after", {24'd0, busy}, 32'h00);
        chk("total_writes", n_writes, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
